// File: rtl/plot_pkg.sv
// Shared constants for the sprite plot engine: FSM encoding, default screen
// geometry and coordinate/colour widths.
package plot_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Counter width for n states, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_plot_engine_if.sv
// Controller-side request/sprite bus and framebuffer pixel bus of the plot engine.
interface sprite_plot_engine_if import plot_pkg::*; #(
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOUR_W    = DEF_COLOUR_W,
    parameter int NUM_SPRITES = 2
);
    logic                            start;
    logic                            mode;
    logic [COLOUR_W-1:0]             bg_colour;
    logic [NUM_SPRITES-1:0]          spr_en;
    logic [NUM_SPRITES*X_W-1:0]      spr_x;
    logic [NUM_SPRITES*Y_W-1:0]      spr_y;
    logic [NUM_SPRITES*COLOUR_W-1:0] spr_colour;
    logic [X_W-1:0]                  x;
    logic [Y_W-1:0]                  y;
    logic [COLOUR_W-1:0]             colour;
    logic                            plot;
    logic                            busy;
    logic                            done;

    modport master (
        output start, mode, bg_colour, spr_en, spr_x, spr_y, spr_colour,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, mode, bg_colour, spr_en, spr_x, spr_y, spr_colour,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/scan_counter_2d.sv
// Row-major W x H position counter; nx/ny give the following position so the
// caller can register it alongside the advance.
module scan_counter_2d import plot_pkg::*; #(
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int XW = cnt_w(W),
    parameter int YW = cnt_w(H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny,
    output logic          last
);
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          x_end, y_end;

    assign x_end = (cx_q == XW'(W - 1));
    assign y_end = (cy_q == YW'(H - 1));
    assign last  = x_end && y_end;

    always_comb begin
        nx   = x_end ? '0 : cx_q + XW'(1);
        ny   = x_end ? (y_end ? '0 : cy_q + YW'(1)) : cy_q;
        cx_d = cx_q;
        cy_d = cy_q;
        if (clr) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en) begin
            cx_d = nx;
            cy_d = ny;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end
endmodule

// File: rtl/sprite_plot_engine.sv
// Framebuffer write engine: clears the screen or draws clipped solid sprites,
// one registered pixel per clock, with busy/done handshake.
module sprite_plot_engine import plot_pkg::*; #(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOUR_W    = DEF_COLOUR_W,
    parameter int NUM_SPRITES = 2,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    sprite_plot_engine_if.slave  bus
);
    localparam int SLOT_W = cnt_w(NUM_SPRITES);
    localparam int CLR_XW = cnt_w(SCREEN_W);
    localparam int CLR_YW = cnt_w(SCREEN_H);
    localparam int SPR_XW = cnt_w(SPR_W);
    localparam int SPR_YW = cnt_w(SPR_H);

    logic [2:0]                      state_q, state_d;
    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic [COLOUR_W-1:0]             bg_q, bg_d;
    logic [NUM_SPRITES-1:0]          en_q, en_d;
    logic [NUM_SPRITES*X_W-1:0]      spr_x_q, spr_x_d;
    logic [NUM_SPRITES*Y_W-1:0]      spr_y_q, spr_y_d;
    logic [NUM_SPRITES*COLOUR_W-1:0] spr_col_q, spr_col_d;
    logic [X_W-1:0]                  x_q, x_d;
    logic [Y_W-1:0]                  y_q, y_d;
    logic [COLOUR_W-1:0]             colour_q, colour_d;
    logic                            plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [X_W-1:0]      slot_x   [NUM_SPRITES];
    logic [Y_W-1:0]      slot_y   [NUM_SPRITES];
    logic [COLOUR_W-1:0] slot_col [NUM_SPRITES];

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
        assign slot_x[gi]   = spr_x_q[gi*X_W +: X_W];
        assign slot_y[gi]   = spr_y_q[gi*Y_W +: Y_W];
        assign slot_col[gi] = spr_col_q[gi*COLOUR_W +: COLOUR_W];
    end

    logic [CLR_XW-1:0] clr_nx;
    logic [CLR_YW-1:0] clr_ny;
    logic              clr_last;
    logic [SPR_XW-1:0] spr_nx, off_x;
    logic [SPR_YW-1:0] spr_ny, off_y;
    logic              spr_last;

    scan_counter_2d #(.W(SCREEN_W), .H(SCREEN_H), .XW(CLR_XW), .YW(CLR_YW)) u_clr_scan (
        .clk(CLOCK_50), .rst_n(resetn),
        .clr(state_q != ST_CLEAR), .en(state_q == ST_CLEAR),
        .nx(clr_nx), .ny(clr_ny), .last(clr_last)
    );

    scan_counter_2d #(.W(SPR_W), .H(SPR_H), .XW(SPR_XW), .YW(SPR_YW)) u_spr_scan (
        .clk(CLOCK_50), .rst_n(resetn),
        .clr(state_q == ST_LOAD), .en(state_q == ST_DRAW),
        .nx(spr_nx), .ny(spr_ny), .last(spr_last)
    );

    // In LOAD the counter still holds the previous slot, so the first pixel uses offset 0.
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    logic         in_screen, last_slot, emit;

    assign off_x     = (state_q == ST_LOAD) ? '0 : spr_nx;
    assign off_y     = (state_q == ST_LOAD) ? '0 : spr_ny;
    assign sx        = {1'b0, slot_x[slot_q]} + (X_W+1)'(off_x);
    assign sy        = {1'b0, slot_y[slot_q]} + (Y_W+1)'(off_y);
    assign in_screen = (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));
    assign last_slot = (slot_q == SLOT_W'(NUM_SPRITES - 1));

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        bg_d      = bg_q;
        en_d      = en_q;
        spr_x_d   = spr_x_q;
        spr_y_d   = spr_y_q;
        spr_col_d = spr_col_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        emit      = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                bg_d      = bus.bg_colour;
                en_d      = bus.spr_en;
                spr_x_d   = bus.spr_x;
                spr_y_d   = bus.spr_y;
                spr_col_d = bus.spr_colour;
                slot_d    = '0;
                busy_d    = 1'b1;
                if (bus.mode) begin
                    state_d  = ST_CLEAR;
                    x_d      = '0;
                    y_d      = '0;
                    colour_d = bus.bg_colour;
                    plot_d   = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CLEAR: if (clr_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                x_d      = X_W'(clr_nx);
                y_d      = Y_W'(clr_ny);
                colour_d = bg_q;
                plot_d   = 1'b1;
            end
            ST_LOAD: if (en_q[slot_q]) begin
                state_d = ST_DRAW;
                emit    = 1'b1;
            end else if (last_slot) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
            ST_DRAW: if (!spr_last) begin
                emit = 1'b1;
            end else if (last_slot) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_LOAD;
                slot_d  = slot_q + SLOT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Clipped pixels consume their cycle but leave the pixel bus untouched.
        if (emit) begin
            plot_d = in_screen;
            if (in_screen) begin
                x_d      = sx[X_W-1:0];
                y_d      = sy[Y_W-1:0];
                colour_d = slot_col[slot_q];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            bg_q      <= '0;
            en_q      <= '0;
            spr_x_q   <= '0;
            spr_y_q   <= '0;
            spr_col_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            bg_q      <= bg_d;
            en_q      <= en_d;
            spr_x_q   <= spr_x_d;
            spr_y_q   <= spr_y_d;
            spr_col_q <= spr_col_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_sprite_plot_engine.sv
// Directed bench: a 4x3 instance for clear/reset cases and a default-size
// instance for sprite draw, clipping, overlap and handshake cases.
module tb_sprite_plot_engine;
    import plot_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sprite_plot_engine_if #(.X_W(8), .Y_W(7), .COLOUR_W(6), .NUM_SPRITES(2)) bus_s ();
    sprite_plot_engine_if #(.X_W(8), .Y_W(7), .COLOUR_W(6), .NUM_SPRITES(2)) bus_d ();

    sprite_plot_engine #(.SCREEN_W(4), .SCREEN_H(3)) dut_s (
        .CLOCK_50(clk), .resetn(resetn), .bus(bus_s)
    );
    sprite_plot_engine dut_d (
        .CLOCK_50(clk), .resetn(resetn), .bus(bus_d)
    );

    int vecs = 0;
    int errs = 0;
    int nplot = 0;
    logic [5:0] fb [256][128];
    logic [7:0] lx = '0;
    logic [6:0] ly = '0;
    logic [5:0] lc = '0;

    function automatic logic [25:0] pk(input logic p, input logic b, input logic d,
                                       input logic [7:0] x, input logic [6:0] y,
                                       input logic [5:0] c);
        return {p, b, d, x, y, c};
    endfunction

    function automatic logic [25:0] obs_s();
        return pk(bus_s.plot, bus_s.busy, bus_s.done, bus_s.x, bus_s.y, bus_s.colour);
    endfunction

    function automatic logic [25:0] obs_d();
        return pk(bus_d.plot, bus_d.busy, bus_d.done, bus_d.x, bus_d.y, bus_d.colour);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample; pixels written by the default instance land in fb.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_d.plot === 1'b1) begin
            fb[bus_d.x][bus_d.y] = bus_d.colour;
            nplot++;
        end
    endtask

    task automatic clear_small(input string tag, input logic [5:0] bg);
        bus_s.mode      = 1'b1;
        bus_s.bg_colour = bg;
        bus_s.start     = 1'b1;
        tick();
        bus_s.start     = 1'b0;
        bus_s.bg_colour = ~bg;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("%s px%0d", tag, k), obs_s(), pk(1'b1, 1'b1, 1'b0, 8'(k % 4), 7'(k / 4), bg));
            bus_s.start = (k == 3);
            tick();
        end
        check({tag, " done"}, obs_s(), pk(1'b0, 1'b1, 1'b1, 8'd3, 7'd2, bg));
        tick();
        check({tag, " idle"}, obs_s(), pk(1'b0, 1'b0, 1'b0, 8'd3, 7'd2, bg));
        tick();
        check({tag, " no 2nd op"}, obs_s(), pk(1'b0, 1'b0, 1'b0, 8'd3, 7'd2, bg));
    endtask

    task automatic sprite_op(input string tag, input logic [1:0] en,
                             input int x0, input int y0, input logic [5:0] c0,
                             input int x1, input int y1, input logic [5:0] c1,
                             input int want_plots);
        int xs [2];
        int ys [2];
        logic [5:0] cs [2];
        int px, py;
        logic pl;
        xs = '{x0, x1};
        ys = '{y0, y1};
        cs = '{c0, c1};
        bus_d.mode       = 1'b0;
        bus_d.spr_en     = en;
        bus_d.spr_x      = {8'(x1), 8'(x0)};
        bus_d.spr_y      = {7'(y1), 7'(y0)};
        bus_d.spr_colour = {c1, c0};
        bus_d.start      = 1'b1;
        tick();
        bus_d.start      = 1'b0;
        bus_d.mode       = 1'b1;
        bus_d.spr_en     = ~en;
        bus_d.spr_x      = ~bus_d.spr_x;
        bus_d.spr_colour = ~bus_d.spr_colour;
        nplot = 0;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s load%0d", tag, s), obs_d(), pk(1'b0, 1'b1, 1'b0, lx, ly, lc));
            tick();
            if (en[s]) begin
                for (int k = 0; k < 256; k++) begin
                    px = xs[s] + k % 16;
                    py = ys[s] + k / 16;
                    pl = (px < 160) && (py < 120);
                    if (pl) begin
                        lx = px[7:0];
                        ly = py[6:0];
                        lc = cs[s];
                    end
                    check($sformatf("%s s%0d px%0d", tag, s, k), obs_d(), pk(pl, 1'b1, 1'b0, lx, ly, lc));
                    tick();
                end
            end
        end
        check({tag, " done"}, obs_d(), pk(1'b0, 1'b1, 1'b1, lx, ly, lc));
        tick();
        check({tag, " idle"}, obs_d(), pk(1'b0, 1'b0, 1'b0, lx, ly, lc));
        check({tag, " plots"}, nplot, want_plots);
        bus_d.mode = 1'b0;
    endtask

    initial begin
        bus_s.start = 1'b0; bus_s.mode = 1'b0; bus_s.bg_colour = '0; bus_s.spr_en = '0;
        bus_s.spr_x = '0;   bus_s.spr_y = '0;  bus_s.spr_colour = '0;
        bus_d.start = 1'b0; bus_d.mode = 1'b0; bus_d.bg_colour = '0; bus_d.spr_en = '0;
        bus_d.spr_x = '0;   bus_d.spr_y = '0;  bus_d.spr_colour = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset small", obs_s(), '0);
        check("reset default", obs_d(), '0);
        resetn = 1'b1;
        tick();

        clear_small("clear 4x3", 6'h15);

        sprite_op("slot0 at 10,20", 2'b01, 10, 20, 6'h30, 50, 60, 6'h11, 256);
        sprite_op("clip 150,110", 2'b01, 150, 110, 6'h2A, 0, 0, 6'h01, 100);

        fb[0][0] = '0; fb[15][15] = '0; fb[8][3] = '0;
        sprite_op("overlap", 2'b11, 0, 0, 6'h03, 0, 0, 6'h0C, 512);
        check("overlap fb 0,0", fb[0][0], 6'h0C);
        check("overlap fb 15,15", fb[15][15], 6'h0C);
        check("overlap fb 8,3", fb[8][3], 6'h0C);

        // Empty mask with start held high through busy and DONE.
        nplot = 0;
        bus_d.spr_en = 2'b00;
        bus_d.mode   = 1'b0;
        bus_d.start  = 1'b1;
        tick();
        check("empty load0", obs_d(), pk(1'b0, 1'b1, 1'b0, lx, ly, lc));
        tick();
        check("empty load1", obs_d(), pk(1'b0, 1'b1, 1'b0, lx, ly, lc));
        tick();
        check("empty done", obs_d(), pk(1'b0, 1'b1, 1'b1, lx, ly, lc));
        tick();
        bus_d.start = 1'b0;
        check("empty idle", obs_d(), pk(1'b0, 1'b0, 1'b0, lx, ly, lc));
        tick();
        check("empty no 2nd op", obs_d(), pk(1'b0, 1'b0, 1'b0, lx, ly, lc));
        check("empty plots", nplot, 0);

        // Reset mid-clear, then a fresh clear from the origin.
        bus_s.mode      = 1'b1;
        bus_s.bg_colour = 6'h3F;
        bus_s.start     = 1'b1;
        tick();
        bus_s.start = 1'b0;
        repeat (5) tick();
        check("mid clear px5", obs_s(), pk(1'b1, 1'b1, 1'b0, 8'd1, 7'd1, 6'h3F));
        #3 resetn = 1'b0;
        #1;
        check("async reset", obs_s(), '0);
        tick();
        check("held in reset", obs_s(), '0);
        resetn = 1'b1;
        tick();
        check("after reset idle", obs_s(), '0);
        clear_small("clear after reset", 6'h0A);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sprite_plot_engine.md
Name: sprite_plot_engine

Overview:
- Parametrised pixel-write engine for the vga_adapter framebuffer interface (x, y, colour, plot).
- On a start request it either clears the screen to a background colour or draws up to NUM_SPRITES solid rectangular sprites at latched positions, emitting one pixel per clock.
- It replaces the always-asserted plot of the current game top with a true per-pixel write strobe and a busy/done handshake for the game controller.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 6, colour width (2 bits per channel).
- NUM_SPRITES, 2, number of sprite slots.
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = draw sprites, 1 = clear screen.
- bg_colour  in  COLOUR_W  clear colour.
- spr_en  in  NUM_SPRITES  per-slot enable mask.
- spr_x  in  NUM_SPRITES*X_W  packed top-left x; slot i occupies bits [i*X_W +: X_W].
- spr_y  in  NUM_SPRITES*Y_W  packed top-left y.
- spr_colour  in  NUM_SPRITES*COLOUR_W  packed fill colour.
- x  out  X_W  pixel x to the adapter.
- y  out  Y_W  pixel y to the adapter.
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  write strobe.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, resetn=0): all outputs 0, state IDLE, all latched inputs cleared. Reset asserted mid-operation aborts immediately; there is no done pulse.
- All outputs are registered.
- IDLE:
  - start=1 latches mode, bg_colour, spr_en, spr_x, spr_y and spr_colour, and sets busy=1 on the next edge.
  - start is ignored while busy=1.
  - Changes to the inputs during an operation have no effect.
- CLEAR (mode=1):
  - Row-major scan, x fastest, from (0,0) to (SCREEN_W-1, SCREEN_H-1).
  - Each pixel drives plot=1 and colour=bg_colour.
  - The first pixel appears on the outputs in the cycle after start is sampled.
  - Exactly SCREEN_W*SCREEN_H plot cycles, then DONE.
- LOAD (mode=0):
  - One cycle per slot i, with plot=0.
  - Initialises the scan counter to (0,0) relative to slot i.
  - A disabled slot goes straight to the next LOAD, or to DONE after the last slot.
- DRAW:
  - SPR_W*SPR_H cycles, row-major.
  - Outputs are x = spr_x[i] + cx and y = spr_y[i] + cy, computed at X_W+1 and Y_W+1 bits.
  - plot=1 only if x < SCREEN_W and y < SCREEN_H; clipped pixels take the cycle with plot=0 and no wrap-around.
  - After the last pixel of slot i: LOAD for i+1, or DONE if i = NUM_SPRITES-1.
- Draw order: ascending slot index, so higher slots overwrite lower slots.
- DONE: one cycle with done=1, busy=1 and plot=0; then IDLE with busy=0. start in the DONE cycle is ignored.
- When plot=0, x, y and colour hold their last values.
- Timing per operation, from the start-sampling edge to the done cycle inclusive:
  - Clear: SCREEN_W*SCREEN_H + 1 cycles.
  - Sprites: NUM_SPRITES + (number of enabled slots)*SPR_W*SPR_H + 1 cycles.
- All-disabled mask: NUM_SPRITES LOAD cycles, then DONE, with no plots.

Decomposition:
- Package plot_pkg holds:
  - the state encoding (IDLE, CLEAR, LOAD, DRAW, DONE);
  - the default screen constants (160, 120);
  - the coordinate and colour width constants.
- One sub-module, scan_counter_2d:
  - parametrised width/height counter with clear, enable and a last flag;
  - reused for both the CLEAR and the DRAW scans.

Test Plan:
- Clear with SCREEN_W=4, SCREEN_H=3, start, mode=1, bg_colour=6'h15 -> 12 consecutive plot cycles (0,0),(1,0)..(3,2), colour 6'h15, then done=1 in cycle 13, busy low in cycle 14.
- Defaults, mode=0, spr_en=2'b01, spr_x[0]=10, spr_y[0]=20, colour 6'h30 -> 1 LOAD, 256 plots covering (10..25, 20..35), 1 LOAD for slot 1, done in cycle 259.
- Clipping: spr_x[0]=150, spr_y[0]=110, slot 0 only -> 100 plot=1 cycles (x 150..159, y 110..119), 156 plot=0 cycles, no x/y wrap past 159/119.
- Overlap: both slots at (0,0), colours 6'h03 and 6'h0C -> slot 1's pixels emitted after slot 0's, last write per pixel is 6'h0C; done after 2+512+1 cycles.
- start pulses while busy and in the DONE cycle -> ignored, no second done; spr_en=0 -> done 3 cycles after start (2 LOAD + DONE), zero plots.
- resetn low midway through a clear -> x, y, colour, plot, busy, done all 0 asynchronously; after release, a fresh start produces a full clear from (0,0).
